sram_bus_bridge: RTL

//  Initiator for the 16-bit byte-lane async SRAM port (en / wen[1:0] / addr / wdata / rdata).
//  - Accepts 32-bit word requests from the CPU load/store path over a valid/ready handshake.
//  - Splits each request into two halfword RAM accesses, low half first.
//  - Returns one 32-bit response per request over a valid/ready handshake.

---
 rtl/sram_bus_bridge.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/sram_bus_bridge.sv
// sram_bus_bridge: turns 32-bit word requests into two 16-bit halfword
// accesses on an async byte-lane SRAM port, then returns one response.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | req_ready high, waiting for a request
//   LO    | low halfword access at base, ram_en held for the phase
//   HI    | high halfword access at base+1, ram_en held for the phase
//   RESP  | resp_valid high, waiting for resp_ready
module sram_bus_bridge #(
    parameter int ADDR_W      = 20,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [31:0]       req_addr,
    input  logic [3:0]        req_wstrb,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              ram_en,
    output logic [1:0]        ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_wdata,
    input  logic [15:0]       ram_rdata
);

    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wr_q, wr_d;
    logic [3:0]         wstrb_q, wstrb_d;
    logic [15:0]        wdata_hi_q, wdata_hi_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
    logic [15:0]        ram_wdata_q, ram_wdata_d;

    logic               last_cycle;
    logic [ADDR_W-1:0]  req_base;

    // Byte-offset bits and bits beyond the RAM range are dropped on purpose.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[31:ADDR_W+1], req_addr[1:0]};

    assign req_base   = {req_addr[ADDR_W:2], 1'b0};
    assign last_cycle = (cnt_q == CNT_W'(WAIT_CYCLES));

    // State and datapath registers; reset drops any in-flight request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            wstrb_q     <= '0;
            wdata_hi_q  <= '0;
            base_q      <= '0;
            rdata_q     <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            wstrb_q     <= wstrb_d;
            wdata_hi_q  <= wdata_hi_d;
            base_q      <= base_d;
            rdata_q     <= rdata_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    // Next-state logic; ram address/data are loaded on entry to each phase
    // so the RAM port only ever sees registered values.
    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        wr_d        = wr_q;
        wstrb_d     = wstrb_q;
        wdata_hi_d  = wdata_hi_q;
        base_d      = base_q;
        rdata_d     = rdata_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wr_d       = req_wr;
                    wstrb_d    = req_wstrb;
                    wdata_hi_d = req_wdata[31:16];
                    base_d     = req_base;
                    rdata_d    = '0;
                    if (req_wr && (req_wstrb == 4'b0000)) begin
                        state_d = RESP;
                    end else if (req_wr && (req_wstrb[1:0] == 2'b00)) begin
                        state_d     = HI;
                        ram_addr_d  = req_base + ADDR_W'(1);
                        ram_wdata_d = req_wdata[31:16];
                    end else begin
                        state_d     = LO;
                        ram_addr_d  = req_base;
                        ram_wdata_d = req_wdata[15:0];
                    end
                end
            end
            LO: begin
                if (!last_cycle) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    if (!wr_q) begin
                        rdata_d[15:0] = ram_rdata;
                    end
                    if (wr_q && (wstrb_q[3:2] == 2'b00)) begin
                        state_d = RESP;
                    end else begin
                        state_d     = HI;
                        ram_addr_d  = base_q + ADDR_W'(1);
                        ram_wdata_d = wdata_hi_q;
                    end
                end
            end
            HI: begin
                if (!last_cycle) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    if (!wr_q) begin
                        rdata_d[31:16] = ram_rdata;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Port outputs decoded from registered state only.
    always_comb begin
        req_ready  = (state_q == IDLE);
        resp_valid = (state_q == RESP);
        resp_rdata = rdata_q;
        ram_en     = (state_q == LO) || (state_q == HI);
        ram_wen    = 2'b00;
        if (wr_q && last_cycle) begin
            if (state_q == LO) begin
                ram_wen = wstrb_q[1:0];
            end else if (state_q == HI) begin
                ram_wen = wstrb_q[3:2];
            end
        end
        ram_addr  = ram_addr_q;
        ram_wdata = ram_wdata_q;
    end

endmodule
